// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-granular main memory between the instruction
// cache (client 0) and the data cache (client 1). One line transaction is in
// flight at a time; the winner is chosen round-robin and its request is
// captured so the memory sees a stable copy until it completes.
module mem_arbiter #(
    parameter  int LINE_ADDR_LEN = 3,
    parameter  int ADDR_LEN      = 10,
    localparam int LW            = 32 << LINE_ADDR_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          c_rd_req,
    input  logic [1:0]          c_wr_req,
    input  logic [ADDR_LEN-1:0] c0_addr,
    input  logic [ADDR_LEN-1:0] c1_addr,
    input  logic [LW-1:0]       c0_wr_line,
    input  logic [LW-1:0]       c1_wr_line,
    output logic [1:0]          c_gnt,
    output logic [LW-1:0]       c0_rd_line,
    output logic [LW-1:0]       c1_rd_line,
    output logic                mem_rd_req,
    output logic                mem_wr_req,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [LW-1:0]       mem_wr_line,
    input  logic [LW-1:0]       mem_rd_line,
    input  logic                mem_gnt,
    output logic [15:0]         gnt_cnt0,
    output logic [15:0]         gnt_cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              next_state;
    logic                rr_ptr;
    logic                owner;
    logic                op_wr;
    logic [ADDR_LEN-1:0] addr_q;
    logic [LW-1:0]       wline_q;
    logic                req0;
    logic                req1;
    logic                any_req;
    logic                winner;
    logic                win_wr;

    // Pick the winner: the preferred client on contention, otherwise the lone requester; a write beats a read from the same client.
    always_comb begin
        req0    = c_rd_req[0] | c_wr_req[0];
        req1    = c_rd_req[1] | c_wr_req[1];
        any_req = req0 | req1;
        winner  = (req0 && req1) ? rr_ptr : req1;
        win_wr  = c_wr_req[winner];
    end

    // State register; reset abandons any in-flight transaction without a completion pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and memory/client handshakes; memory side is driven only from the captured copy while BUSY.
    always_comb begin
        next_state  = state;
        mem_rd_req  = 1'b0;
        mem_wr_req  = 1'b0;
        mem_addr    = '0;
        mem_wr_line = '0;
        c_gnt       = 2'b00;
        case (state)
            IDLE: begin
                if (any_req) begin
                    next_state = BUSY;
                end
            end
            BUSY: begin
                mem_rd_req  = ~op_wr;
                mem_wr_req  = op_wr;
                mem_addr    = addr_q;
                mem_wr_line = wline_q;
                if (mem_gnt) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                c_gnt      = owner ? 2'b10 : 2'b01;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Capture the winning client's id, op, address and write line when a transaction starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner   <= 1'b0;
            op_wr   <= 1'b0;
            addr_q  <= '0;
            wline_q <= '0;
        end else if (state == IDLE && any_req) begin
            owner   <= winner;
            op_wr   <= win_wr;
            addr_q  <= winner ? c1_addr : c0_addr;
            wline_q <= winner ? c1_wr_line : c0_wr_line;
        end
    end

    // Return the memory line to the owner on a read completion; writes leave the held lines alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c0_rd_line <= '0;
            c1_rd_line <= '0;
        end else if (state == BUSY && mem_gnt && !op_wr) begin
            if (owner) begin
                c1_rd_line <= mem_rd_line;
            end else begin
                c0_rd_line <= mem_rd_line;
            end
        end
    end

    // On completion hand preference to the other client and bump the owner's saturating grant counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr   <= 1'b0;
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else if (state == DONE) begin
            rr_ptr <= ~owner;
            if (!owner && gnt_cnt0 != 16'hFFFF) begin
                gnt_cnt0 <= gnt_cnt0 + 16'd1;
            end
            if (owner && gnt_cnt1 != 16'hFFFF) begin
                gnt_cnt1 <= gnt_cnt1 + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: two client drivers, a latency-programmable
// memory model, and scoreboards for memory-side and client-side traffic.
module tb_mem_arbiter;

    localparam int LW = 256;

    typedef struct {
        logic        wr;
        logic        both;
        logic [9:0]  addr;
        logic [LW-1:0] line;
        logic        glitch;
        logic [9:0]  alt;
    } cmd_t;

    typedef struct {
        logic          client;
        logic [LW-1:0] rd_line;
        logic [15:0]   cnt;
    } gnt_exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd0, wr0, rd1, wr1;
    logic [1:0]    c_rd_req, c_wr_req;
    logic [9:0]    c0_addr, c1_addr;
    logic [LW-1:0] c0_wr_line, c1_wr_line;
    logic [1:0]    c_gnt;
    logic [LW-1:0] c0_rd_line, c1_rd_line;
    logic          mem_rd_req, mem_wr_req;
    logic [9:0]    mem_addr;
    logic [LW-1:0] mem_wr_line;
    logic [LW-1:0] mem_rd_line;
    logic          mem_gnt;
    logic [15:0]   gnt_cnt0, gnt_cnt1;

    int            check_cnt = 0;
    int            pass_cnt  = 0;
    int            mem_lat   = 2;
    int            mwait     = 0;

    cmd_t          cmd_q0[$];
    cmd_t          cmd_q1[$];
    cmd_t          mem_exp_q[$];
    gnt_exp_t      gnt_exp_q[$];
    logic [LW-1:0] m_rd_line[2];
    logic [15:0]   m_cnt[2];

    localparam logic [LW-1:0] GARBAGE = {32{8'hA5}};

    assign c_rd_req = {rd1, rd0};
    assign c_wr_req = {wr1, wr0};

    mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .c_rd_req   (c_rd_req),
        .c_wr_req   (c_wr_req),
        .c0_addr    (c0_addr),
        .c1_addr    (c1_addr),
        .c0_wr_line (c0_wr_line),
        .c1_wr_line (c1_wr_line),
        .c_gnt      (c_gnt),
        .c0_rd_line (c0_rd_line),
        .c1_rd_line (c1_rd_line),
        .mem_rd_req (mem_rd_req),
        .mem_wr_req (mem_wr_req),
        .mem_addr   (mem_addr),
        .mem_wr_line(mem_wr_line),
        .mem_rd_line(mem_rd_line),
        .mem_gnt    (mem_gnt),
        .gnt_cnt0   (gnt_cnt0),
        .gnt_cnt1   (gnt_cnt1)
    );

    always #5 clk = ~clk;

    // Memory contents: address 0x015 holds 0x1000+k, every other line holds {addr,16'h0}+k.
    function automatic logic [LW-1:0] line_for(input logic [9:0] a);
        logic [LW-1:0] l;
        l = '0;
        for (int k = 0; k < 8; k++) begin
            l[32*k +: 32] = (a == 10'h015) ? 32'h1000 + 32'(k) : {6'd0, a, 16'd0} + 32'(k);
        end
        return l;
    endfunction

    task automatic checkOutput(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        check_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        check_cnt++;
        $display("[TB] FAIL %s: got timeout required event within budget", name);
    endtask

    task automatic applyStimulus(input logic client, input logic wr, input logic both,
                                 input logic [9:0] addr, input logic [LW-1:0] line,
                                 input logic glitch, input logic [9:0] alt);
        cmd_t c;
        c = '{wr, both, addr, line, glitch, alt};
        if (client) cmd_q1.push_back(c);
        else        cmd_q0.push_back(c);
    endtask

    // Push the expected memory transaction and client completion in service order.
    task automatic expect_txn(input logic client, input logic wr, input logic [9:0] addr, input logic [LW-1:0] line);
        gnt_exp_t g;
        mem_exp_q.push_back('{wr, 1'b0, addr, line, 1'b0, 10'd0});
        if (!wr) m_rd_line[client] = line_for(addr);
        if (m_cnt[client] != 16'hFFFF) m_cnt[client] = m_cnt[client] + 16'd1;
        g = '{client, m_rd_line[client], m_cnt[client]};
        gnt_exp_q.push_back(g);
    endtask

    task automatic clear_model();
        m_rd_line[0] = '0;
        m_rd_line[1] = '0;
        m_cnt[0]     = '0;
        m_cnt[1]     = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int w;
        w = 0;
        while (!(gnt_exp_q.size() == 0 && mem_exp_q.size() == 0 && cmd_q0.size() == 0 &&
                 cmd_q1.size() == 0 && !rd0 && !wr0 && !rd1 && !wr1) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 1000) fail(name);
        @(negedge clk);
    endtask

    // Memory model: answers each request after mem_lat extra cycles with a one-cycle gnt.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_gnt     <= 1'b0;
            mwait       <= 0;
            mem_rd_line <= GARBAGE;
        end else begin
            mem_gnt     <= 1'b0;
            mem_rd_line <= GARBAGE;
            if (!mem_gnt && (mem_rd_req || mem_wr_req)) begin
                if (mwait >= mem_lat) begin
                    mem_gnt     <= 1'b1;
                    mem_rd_line <= line_for(mem_addr);
                    mwait       <= 0;
                end else begin
                    mwait <= mwait + 1;
                end
            end
        end
    end

    // Client 0 driver: holds a request until its c_gnt bit, then moves on the cycle after.
    initial begin : drv0
        cmd_t c;
        int   w;
        rd0 = 1'b0; wr0 = 1'b0; c0_addr = '0; c0_wr_line = '0;
        forever begin
            if (rst === 1'b1 && cmd_q0.size() > 0) begin
                c = cmd_q0.pop_front();
                rd0 = ~c.wr | c.both; wr0 = c.wr; c0_addr = c.addr; c0_wr_line = c.line;
                w = 0;
                do begin
                    @(negedge clk);
                    w++;
                    if (c.glitch && w == 3) c0_addr = c.alt;
                end while (rst === 1'b1 && c_gnt[0] !== 1'b1 && w < 400);
                if (rst !== 1'b1) begin
                    rd0 = 1'b0; wr0 = 1'b0;
                end else if (c_gnt[0] !== 1'b1) begin
                    fail("client0_wait_gnt");
                    rd0 = 1'b0; wr0 = 1'b0;
                end else begin
                    @(posedge clk); #1;
                    if (cmd_q0.size() == 0) begin
                        rd0 = 1'b0; wr0 = 1'b0;
                    end
                end
            end else begin
                rd0 = 1'b0; wr0 = 1'b0;
                @(negedge clk);
            end
        end
    end

    // Client 1 driver: same protocol as client 0.
    initial begin : drv1
        cmd_t c;
        int   w;
        rd1 = 1'b0; wr1 = 1'b0; c1_addr = '0; c1_wr_line = '0;
        forever begin
            if (rst === 1'b1 && cmd_q1.size() > 0) begin
                c = cmd_q1.pop_front();
                rd1 = ~c.wr | c.both; wr1 = c.wr; c1_addr = c.addr; c1_wr_line = c.line;
                w = 0;
                do begin
                    @(negedge clk);
                    w++;
                    if (c.glitch && w == 3) c1_addr = c.alt;
                end while (rst === 1'b1 && c_gnt[1] !== 1'b1 && w < 400);
                if (rst !== 1'b1) begin
                    rd1 = 1'b0; wr1 = 1'b0;
                end else if (c_gnt[1] !== 1'b1) begin
                    fail("client1_wait_gnt");
                    rd1 = 1'b0; wr1 = 1'b0;
                end else begin
                    @(posedge clk); #1;
                    if (cmd_q1.size() == 0) begin
                        rd1 = 1'b0; wr1 = 1'b0;
                    end
                end
            end else begin
                rd1 = 1'b0; wr1 = 1'b0;
                @(negedge clk);
            end
        end
    end

    // Memory-side monitor: op/addr/line at each new request, stable address, zeroed bus and 2-cycle gaps while idle.
    initial begin : mem_mon
        cmd_t        e;
        logic        prev;
        logic        cur;
        logic        first;
        int          gap;
        logic [9:0]  hold_addr;
        prev = 1'b0; first = 1'b1; gap = 0; hold_addr = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                prev = 1'b0; first = 1'b1; gap = 0;
            end else begin
                cur = mem_rd_req | mem_wr_req;
                if (cur && !prev) begin
                    if (mem_exp_q.size() == 0) begin
                        check_cnt++;
                        $display("[TB] FAIL unexpected_mem_req: got addr %h required no request", mem_addr);
                        hold_addr = mem_addr;
                    end else begin
                        e = mem_exp_q.pop_front();
                        checkOutput("mem_op_is_write", LW'(mem_wr_req), LW'(e.wr));
                        checkOutput("mem_addr", LW'(mem_addr), LW'(e.addr));
                        if (e.wr) checkOutput("mem_wr_line", mem_wr_line, e.line);
                        hold_addr = e.addr;
                    end
                    if (!first) checkOutput("mem_idle_gap_ge2", LW'(gap >= 2), LW'(1'b1));
                    first = 1'b0;
                    gap   = 0;
                end else if (cur) begin
                    checkOutput("mem_addr_stable_busy", LW'(mem_addr), LW'(hold_addr));
                end else begin
                    gap++;
                    checkOutput("mem_bus_zero_idle", LW'(mem_addr == '0 && mem_wr_line == '0), LW'(1'b1));
                end
                prev = cur;
            end
        end
    end

    // Client-side monitor: pops the expected completion on every c_gnt pulse.
    initial begin : gnt_mon
        gnt_exp_t g;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && c_gnt !== 2'b00) begin
                if (gnt_exp_q.size() == 0) begin
                    check_cnt++;
                    $display("[TB] FAIL unexpected_c_gnt: got %b required 00", c_gnt);
                end else begin
                    g = gnt_exp_q.pop_front();
                    checkOutput("c_gnt_owner", LW'(c_gnt), LW'(g.client ? 2'b10 : 2'b01));
                    checkOutput("rd_line", g.client ? c1_rd_line : c0_rd_line, g.rd_line);
                    @(negedge clk);
                    checkOutput("c_gnt_one_cycle", LW'(c_gnt), LW'(2'b00));
                    checkOutput("gnt_cnt", LW'(g.client ? gnt_cnt1 : gnt_cnt0), LW'(g.cnt));
                end
            end
        end
    end

    // Guard against a hung run.
    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got no finish required finish before 50000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int w;
        logic [LW-1:0] dead;
        dead = {8{32'hDEADBEEF}};
        rst = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        checkOutput("reset_mem_req", LW'({mem_rd_req, mem_wr_req}), LW'(2'b00));
        checkOutput("reset_mem_bus", LW'(mem_addr == '0 && mem_wr_line == '0), LW'(1'b1));
        checkOutput("reset_c_gnt", LW'(c_gnt), LW'(2'b00));
        checkOutput("reset_rd_lines", LW'(c0_rd_line == '0 && c1_rd_line == '0), LW'(1'b1));
        checkOutput("reset_counters", LW'({gnt_cnt0, gnt_cnt1}), LW'(32'd0));
        rst = 1'b1;

        // Single read from client 0, with an address change mid-BUSY that must be ignored.
        @(posedge clk); #1;
        mem_lat = 6;
        expect_txn(1'b0, 1'b0, 10'h015, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, 10'h015, '0, 1'b1, 10'h3FF);
        @(negedge clk); #1;
        checkOutput("t1_no_mem_req_before_sample", LW'(mem_rd_req), LW'(1'b0));
        @(posedge clk); #1;
        checkOutput("t1_mem_rd_req_next_cycle", LW'(mem_rd_req), LW'(1'b1));
        checkOutput("t1_mem_addr", LW'(mem_addr), LW'(10'h015));
        w = 0;
        while (mem_gnt !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (mem_gnt !== 1'b1) begin
            fail("t1_mem_gnt");
        end else begin
            @(negedge clk);
            checkOutput("t1_c_gnt_after_mem_gnt", LW'(c_gnt), LW'(2'b01));
            checkOutput("t1_c0_word3", LW'(c0_rd_line[127:96]), LW'(32'h1003));
        end
        wait_done("t1_done");
        checkOutput("t1_gnt_cnt0", LW'(gnt_cnt0), LW'(16'd1));

        // Simultaneous: client 0 read and client 1 write (with rd also high) from a fresh reset.
        do_reset();
        @(posedge clk); #1;
        mem_lat = 1;
        expect_txn(1'b0, 1'b0, 10'h001, '0);
        expect_txn(1'b1, 1'b1, 10'h2A0, dead);
        applyStimulus(1'b0, 1'b0, 1'b0, 10'h001, '0, 1'b0, 10'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 10'h2A0, dead, 1'b0, 10'd0);
        wait_done("t2_done");
        checkOutput("t2_c0_rd_line_kept", c0_rd_line, line_for(10'h001));
        checkOutput("t2_c1_rd_line_untouched", c1_rd_line, '0);

        // Fairness: both clients request back-to-back for 8 transactions.
        do_reset();
        @(posedge clk); #1;
        mem_lat = 0;
        for (int i = 0; i < 4; i++) begin
            expect_txn(1'b0, 1'b0, 10'h100 + 10'(i), '0);
            expect_txn(1'b1, 1'b0, 10'h200 + 10'(i), '0);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 10'h100 + 10'(i), '0, 1'b0, 10'd0);
            applyStimulus(1'b1, 1'b0, 1'b0, 10'h200 + 10'(i), '0, 1'b0, 10'd0);
        end
        wait_done("t3_done");
        checkOutput("t3_gnt_cnt0", LW'(gnt_cnt0), LW'(16'd4));
        checkOutput("t3_gnt_cnt1", LW'(gnt_cnt1), LW'(16'd4));

        // Write-back then refill from client 1 while client 0 waits: 1 write, 0 read, 1 read.
        @(posedge clk); #1;
        mem_lat = 4;
        expect_txn(1'b1, 1'b1, 10'h055, {8{32'h0BADF00D}});
        expect_txn(1'b0, 1'b0, 10'h011, '0);
        expect_txn(1'b1, 1'b0, 10'h056, '0);
        applyStimulus(1'b1, 1'b1, 1'b0, 10'h055, {8{32'h0BADF00D}}, 1'b0, 10'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 10'h056, '0, 1'b0, 10'd0);
        w = 0;
        while (mem_wr_req !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (mem_wr_req !== 1'b1) fail("t4_write_start");
        applyStimulus(1'b0, 1'b0, 1'b0, 10'h011, '0, 1'b0, 10'd0);
        wait_done("t4_done");

        // Counter saturation: preload near the top and complete two client-0 reads.
        @(posedge clk); #1;
        force dut.gnt_cnt0 = 16'hFFFE;
        #1;
        release dut.gnt_cnt0;
        m_cnt[0] = 16'hFFFE;
        mem_lat = 0;
        expect_txn(1'b0, 1'b0, 10'h3F0, '0);
        expect_txn(1'b0, 1'b0, 10'h3F1, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, 10'h3F0, '0, 1'b0, 10'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 10'h3F1, '0, 1'b0, 10'd0);
        wait_done("t5_done");
        checkOutput("t5_gnt_cnt0_saturated", LW'(gnt_cnt0), LW'(16'hFFFF));

        // Reset in the middle of a client 1 write: requests drop at once, no completion.
        @(posedge clk); #1;
        mem_lat = 30;
        mem_exp_q.push_back('{1'b1, 1'b0, 10'h1AB, dead, 1'b0, 10'd0});
        applyStimulus(1'b1, 1'b1, 1'b0, 10'h1AB, dead, 1'b0, 10'd0);
        w = 0;
        while (mem_wr_req !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (mem_wr_req !== 1'b1) fail("t6_write_start");
        @(posedge clk); #2;
        rst = 1'b0;
        clear_model();
        #1;
        checkOutput("t6_mem_req_drop_now", LW'({mem_rd_req, mem_wr_req}), LW'(2'b00));
        checkOutput("t6_mem_addr_zero", LW'(mem_addr), LW'(10'd0));
        repeat (3) begin
            @(negedge clk);
            checkOutput("t6_no_c_gnt_in_reset", LW'(c_gnt), LW'(2'b00));
            checkOutput("t6_counters_zero", LW'({gnt_cnt0, gnt_cnt1}), LW'(32'd0));
        end
        checkOutput("t6_rd_lines_zero", LW'(c0_rd_line == '0 && c1_rd_line == '0), LW'(1'b1));
        rst = 1'b1;
        @(posedge clk); #1;
        mem_lat = 2;
        expect_txn(1'b1, 1'b0, 10'h1AC, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, 10'h1AC, '0, 1'b0, 10'd0);
        wait_done("t6_after_reset");
        checkOutput("t6_gnt_cnt1_after", LW'(gnt_cnt1), LW'(16'd1));
        checkOutput("t6_gnt_cnt0_after", LW'(gnt_cnt0), LW'(16'd0));

        checkOutput("end_mem_queue_empty", LW'(mem_exp_q.size()), LW'(0));
        checkOutput("end_gnt_queue_empty", LW'(gnt_exp_q.size()), LW'(0));

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
